// File: rtl/thresholding_loader.sv
// Streams C*(2^N-1) thresholds from AXI-Stream into the thresholding stage's
// AXI-Lite write port, one outstanding write at a time, channel-major order.
module thresholding_loader #(
  parameter int N = 2,
  parameter int M = 8,
  parameter int C = 3,
  localparam int A_BITS = $clog2(C) + N,
  localparam int C_BITS = (C < 2) ? 1 : $clog2(C),
  localparam int TW     = ((M + 7) / 8) * 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              s_axis_tready,
  input  logic              s_axis_tvalid,
  input  logic [TW-1:0]     s_axis_tdata,
  output logic              m_axilite_AWVALID,
  input  logic              m_axilite_AWREADY,
  output logic [A_BITS-1:0] m_axilite_AWADDR,
  output logic              m_axilite_WVALID,
  input  logic              m_axilite_WREADY,
  output logic [31:0]       m_axilite_WDATA,
  output logic [3:0]        m_axilite_WSTRB,
  input  logic              m_axilite_BVALID,
  output logic              m_axilite_BREADY,
  input  logic [1:0]        m_axilite_BRESP
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESP} state_t;

  localparam logic [N-1:0]      IDX_LAST = N'(2**N - 2);
  localparam logic [C_BITS-1:0] CHN_LAST = C_BITS'(C - 1);

  state_t            state, state_nxt;
  logic [N-1:0]      idx;
  logic [C_BITS-1:0] chn;
  logic [M-1:0]      thr;
  logic              aw_done, w_done;
  logic              aw_hs, w_hs, last;

  assign busy              = (state != IDLE);
  assign s_axis_tready     = (state == FETCH);
  assign m_axilite_AWVALID = (state == WRITE) && !aw_done;
  assign m_axilite_WVALID  = (state == WRITE) && !w_done;
  assign m_axilite_BREADY  = (state == RESP);
  // Concatenation is one bit wider than A_BITS when C=1; the cast drops the unused channel bit.
  assign m_axilite_AWADDR  = A_BITS'({chn, idx});
  assign m_axilite_WDATA   = 32'(thr);
  assign m_axilite_WSTRB   = 4'hF;

  assign aw_hs = m_axilite_AWVALID && m_axilite_AWREADY;
  assign w_hs  = m_axilite_WVALID && m_axilite_WREADY;
  assign last  = (idx == IDX_LAST) && (chn == CHN_LAST);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: if (s_axis_tvalid) state_nxt = WRITE;
      WRITE: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = RESP;
      RESP:  if (m_axilite_BVALID) state_nxt = last ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      idx     <= '0;
      chn     <= '0;
      thr     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          done <= 1'b0;
          err  <= 1'b0;
          idx  <= '0;
          chn  <= '0;
        end
        FETCH: if (s_axis_tvalid) begin
          thr     <= s_axis_tdata[M-1:0];
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        // AW and W complete independently; each valid drops after its own handshake.
        WRITE: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        RESP: if (m_axilite_BVALID) begin
          err <= err | (m_axilite_BRESP != 2'b00);
          if (last) begin
            done <= 1'b1;
          end else if (idx == IDX_LAST) begin
            idx <= '0;
            chn <= chn + C_BITS'(1);
          end else begin
            idx <= idx + N'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_thresholding_loader.sv
// Randomised bench for thresholding_loader: reactive stream source and AXI-Lite slave,
// expected addresses/data from channel-major arithmetic. Two instances: C=3/N=2 and C=1/N=3.
module tb_thresholding_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
  always #5 clk = ~clk;

  logic       tvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0] bresp = 2'b00;
  logic [7:0] tdata = 8'h00;

  logic b0, d0, e0, tr0, awv0, wv0, br0;
  logic [3:0] aa0, ws0;
  logic [31:0] wd0;
  logic b1, d1, e1, tr1, awv1, wv1, br1;
  logic [2:0] aa1;
  logic [3:0] ws1;
  logic [31:0] wd1;

  thresholding_loader #(.N(2), .M(8), .C(3)) u_dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .start(start & ~sel), .busy(b0), .done(d0), .err(e0),
    .s_axis_tready(tr0), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .m_axilite_AWVALID(awv0), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(aa0),
    .m_axilite_WVALID(wv0), .m_axilite_WREADY(wready), .m_axilite_WDATA(wd0),
    .m_axilite_WSTRB(ws0), .m_axilite_BVALID(bvalid), .m_axilite_BREADY(br0),
    .m_axilite_BRESP(bresp));

  thresholding_loader #(.N(3), .M(8), .C(1)) u_dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .start(start & sel), .busy(b1), .done(d1), .err(e1),
    .s_axis_tready(tr1), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .m_axilite_AWVALID(awv1), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(aa1),
    .m_axilite_WVALID(wv1), .m_axilite_WREADY(wready), .m_axilite_WDATA(wd1),
    .m_axilite_WSTRB(ws1), .m_axilite_BVALID(bvalid), .m_axilite_BREADY(br1),
    .m_axilite_BRESP(bresp));

  logic busy_s, done_s, err_s, tr_s, awv_s, wv_s, br_s;
  logic [7:0] aa_s;
  logic [31:0] wd_s;
  logic [3:0] ws_s;
  assign busy_s = sel ? b1 : b0;
  assign done_s = sel ? d1 : d0;
  assign err_s  = sel ? e1 : e0;
  assign tr_s   = sel ? tr1 : tr0;
  assign awv_s  = sel ? awv1 : awv0;
  assign wv_s   = sel ? wv1 : wv0;
  assign br_s   = sel ? br1 : br0;
  assign aa_s   = sel ? {5'b0, aa1} : {4'b0, aa0};
  assign wd_s   = sel ? wd1 : wd0;
  assign ws_s   = sel ? ws1 : ws0;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Test knobs and scoreboard state
  int nb = 2, nch = 3, total = 9;
  int aw_dly = 0, w_dly = 0, b_dly = 0, err_at = -1;
  bit rnd = 0, gap = 0;
  int wr_aw = 0, wr_w = 0, wr_b = 0, sidx = 0, gcnt = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, aw_tgt = 0, w_tgt = 0, b_tgt = 0;
  logic [7:0] aw_last = 8'h0;
  bit aw_hs_prev = 0, w_hs_prev = 0;
  logic [7:0] src [64];

  function automatic int exp_addr(input int k);
    int per = (1 << nb) - 1;
    return (k / per) * (1 << nb) + (k % per);
  endfunction

  // Reactive stream source + AXI-Lite slave; inputs change on the falling edge only.
  initial forever begin
    @(negedge clk);
    gcnt++;
    tvalid = gap ? (gcnt % 4 == 0) : 1'b1;
    tdata  = src[sidx % 64];
    if (tr_s) chk("tready_only_fetch", {awv_s, wv_s, br_s, ~busy_s}, 4'h0);
    if (tvalid && tr_s) sidx++;

    if (aw_hs_prev) chk("aw_drop", awv_s, 1'b0);
    if (w_hs_prev)  chk("w_drop", wv_s, 1'b0);
    aw_hs_prev = 0;
    w_hs_prev  = 0;

    if (awv_s) begin
      if (aw_cnt == 0) aw_tgt = rnd ? int'($urandom_range(0, aw_dly)) : aw_dly;
      else chk("aw_stable", aa_s, aw_last);
      aw_last = aa_s;
      awready = (aw_cnt >= aw_tgt);
      aw_cnt++;
      if (awready) begin
        chk("awaddr", aa_s, exp_addr(wr_aw));
        wr_aw++;
        aw_hs_prev = 1;
      end
    end else begin
      awready = 1'b0;
      aw_cnt  = 0;
    end

    if (wv_s) begin
      if (w_cnt == 0) w_tgt = rnd ? int'($urandom_range(0, w_dly)) : w_dly;
      wready = (w_cnt >= w_tgt);
      w_cnt++;
      if (wready) begin
        chk("wdata", wd_s, {24'h0, src[wr_w % 64]});
        chk("wstrb", ws_s, 4'hF);
        wr_w++;
        w_hs_prev = 1;
      end
    end else begin
      wready = 1'b0;
      w_cnt  = 0;
    end

    if (br_s) begin
      if (b_cnt == 0) b_tgt = rnd ? int'($urandom_range(0, b_dly)) : b_dly;
      bvalid = (b_cnt >= b_tgt);
      bresp  = (wr_b == err_at) ? 2'b10 : 2'b00;
      b_cnt++;
      if (bvalid) wr_b++;
    end else begin
      bvalid = 1'b0;
      bresp  = 2'b00;
      b_cnt  = 0;
    end
  end

  task automatic prep(input bit seq);
    nb    = sel ? 3 : 2;
    nch   = sel ? 1 : 3;
    total = nch * ((1 << nb) - 1);
    wr_aw = 0; wr_w = 0; wr_b = 0; sidx = 0;
    for (int k = 0; k < 64; k++) src[k] = seq ? 8'(k + 1) : 8'($urandom_range(0, 255));
  endtask

  task automatic do_load(input bit seq, input int exp_cyc);
    int c = 0;
    prep(seq);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_rise", busy_s, 1'b1);
    chk("tready_rise", tr_s, 1'b1);
    chk("start_clears", {done_s, err_s}, 2'b00);
    while (!done_s && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", done_s, 1'b1);
    if (exp_cyc > 0) chk("done_latency", c, exp_cyc);
    chk("busy_fall", busy_s, 1'b0);
    chk("n_aw", wr_aw, total);
    chk("n_w", wr_w, total);
    chk("n_b", wr_b, total);
    chk("n_beats", sidx, total);
    chk("err_end", err_s, (err_at >= 0 && err_at < total) ? 1'b1 : 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_dut0", {b0, d0, e0, tr0, awv0, wv0, br0}, 7'h0);
    chk("rst_dut1", {b1, d1, e1, tr1, awv1, wv1, br1}, 7'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", {busy_s, done_s, err_s, tr_s}, 4'h0);

    // Zero-wait slave, values 1..9
    do_load(1, 27);

    // AWREADY delayed 3 cycles, WREADY immediate
    aw_dly = 3;
    do_load(0, -1);
    aw_dly = 0;

    // Error response on the 4th write; following load must clear err
    err_at = 3;
    do_load(0, 27);
    err_at = -1;
    do_load(0, 27);

    // Gapped stream with a stray start mid-load
    gap = 1;
    fork
      do_load(0, -1);
      begin
        repeat (12) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("stray_start_busy", busy_s, 1'b1);
      end
    join
    gap = 0;

    // Random stalls everywhere
    rnd = 1; aw_dly = 3; w_dly = 3; b_dly = 3; gap = 1;
    do_load(0, -1);
    rnd = 0; aw_dly = 0; w_dly = 0; b_dly = 0; gap = 0;

    // Reset during WRITE of the 5th threshold
    aw_dly = 2;
    prep(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    begin
      int c = 0;
      bit hit = 0;
      while (!hit && c < 400) begin
        @(negedge clk);
        #2;
        hit = (wr_aw == 4) && awv_s;
        c++;
      end
      chk("reached_write5", hit, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_async", {busy_s, done_s, err_s, tr_s, awv_s, wv_s, br_s}, 7'h0);
    @(negedge clk);
    chk("rst_hold", {busy_s, awv_s, wv_s, br_s}, 4'h0);
    rst_n = 1'b1;
    aw_dly = 0;
    do_load(0, 27);

    // C=1, N=3: seven writes to 0..6
    @(negedge clk);
    sel = 1'b1;
    do_load(1, 21);
    do_load(0, 21);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_chk, 0);
    $fatal(1, "timeout");
  end
endmodule
